sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Serial pattern transmitter. It is the driving end of the single-bit `x` stream that `sequence_detector` consumes.
- Loads a programmable bit pattern and shifts it out MSB-first, one bit per clock, repeated N times.
- Flags completion with a one-cycle `done` pulse.
- Keeps a running count of overlapping "010" occurrences it has emitted. A bench can compare this count directly against the detector's `y` pulses.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits; the width of `pattern`.
- LEN_W, 5: width of `len`. Must hold MAX_LEN.
- CNT_W, 8: width of `repeat_n` and `match_cnt`.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted when 0.
- start  input  1  request a transfer. Sampled only in IDLE.
- pattern  input  MAX_LEN  bit pattern. Bits [len-1:0] are used; pattern[len-1] is sent first.
- len  input  LEN_W  number of pattern bits per repetition.
- repeat_n  input  CNT_W  number of repetitions.
- x  output  1  serial data out.
- valid  output  1  high while `x` carries a pattern bit.
- busy  output  1  high from start acceptance until `done` is asserted.
- done  output  1  one-cycle pulse at the end of the transfer.
- match_cnt  output  CNT_W  count of overlapping "010" triples emitted since the last accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - x=0, valid=0, busy=0, done=0, match_cnt=0.
  - Internal shift register, bit counter, repeat counter and 2-bit history are all cleared.
  - A reset mid-transfer aborts it immediately, with no `done` pulse.
- All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge where start=1, capture pattern, len and repeat_n.
  - len>MAX_LEN is clamped to MAX_LEN.
  - Clear match_cnt and the history register; set busy=1.
  - If effective len=0 or repeat_n=0: go to DONE with no bits sent.
  - Otherwise: go to SHIFT, with the first bit on x in the cycle immediately after the start edge (latency 1).
- SHIFT:
  - Each cycle: valid=1, x = current pattern bit.
  - Bits run pattern[len-1] down to pattern[0].
  - After bit 0:
    - If repetitions remain, reload and send pattern[len-1] in the very next cycle. There is no gap between repetitions.
    - Otherwise go to DONE.
- DONE (exactly 1 cycle):
  - done=1, valid=0, x=0, busy=0.
  - Next state is IDLE.
  - A start arriving in DONE is ignored.
- start while busy (SHIFT or DONE): ignored. It is not queued.
- Total transfer:
  - len*repeat_n valid cycles, then one DONE cycle.
  - done asserts in cycle len*repeat_n+1 after the start edge.
- match_cnt:
  - Increments when the current valid bit and the previous two valid bits are 0,1,0 in emission order.
  - Overlapping matches count; matches spanning a repetition boundary count.
  - The history is cleared only at start acceptance.
  - Updates in the same edge that registers the third bit.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Holds its value after done until the next accepted start.
- When valid=0, x is forced to 0.

Test Plan:
1. pattern=16'h0002, len=3, repeat_n=1, start pulse:
   - x=0,1,0 with valid=1 in cycles 1-3.
   - done=1 in cycle 4; busy low from cycle 4.
   - match_cnt=1.
2. pattern=16'h0012 (10010), len=5, repeat_n=2:
   - x stream 1001010010 in cycles 1-10, no gap between repetitions.
   - done in cycle 11; match_cnt=3.
3. Transfer from test 2 running, start pulsed again in cycle 4:
   - Stream unchanged; exactly one done, in cycle 11.
   - The second start is not queued.
4. reset driven low in cycle 5 of test 2:
   - x, valid, busy and match_cnt go to 0 immediately, without waiting for a clock edge.
   - No done pulse.
   - After reset=1, a new start transmits normally.
5. len=0 or repeat_n=0 with a start pulse:
   - No valid cycles; busy=1 in cycle 1; done=1 in cycle 1... then IDLE in cycle 2.
   - match_cnt=0.
6. CNT_W=4, pattern=4'b0101, len=4, repeat_n=15:
   - 60 alternating bits.
   - match_cnt saturates at 4'hF (the raw count would be 29); done in cycle 61.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a programmable pattern out MSB-first,
// repeated repeat_n times, and counts overlapping "010" triples it emits.
module sequence_generator #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   repeat_n,
  output logic               x,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;   // index of the bit currently on x
  logic [CNT_W-1:0]   rep_q, rep_d;   // repetitions left after the current one
  logic [1:0]         hist_q, hist_d; // [1] older, [0] newer emitted bit
  logic [1:0]         hist_n_q, hist_n_d;
  logic               x_q, x_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_eff;
  logic               zero_xfer;
  logic               last_bit;
  logic               emit;
  logic               emit_bit;
  logic [MAX_LEN-1:0] sel;

  assign len_eff   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign zero_xfer = (len_eff == '0) || (repeat_n == '0);
  assign last_bit  = (idx_q == '0) && (rep_q == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = zero_xfer ? StDone : StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    hist_d   = hist_q;
    hist_n_d = hist_n_q;
    cnt_d    = cnt_q;
    x_d      = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    emit     = 1'b0;
    sel      = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d    = pattern;
          len_d    = len_eff;
          rep_d    = repeat_n - CNT_W'(1);
          cnt_d    = '0;
          hist_d   = '0;
          hist_n_d = '0;
          // A zero-length transfer still shows busy for its single done cycle
          busy_d   = 1'b1;
          if (zero_xfer) begin
            done_d = 1'b1;
          end else begin
            idx_d = len_eff - LEN_W'(1);
            sel   = pattern >> (len_eff - LEN_W'(1));
            emit  = 1'b1;
          end
        end
      end
      StShift: begin
        if (last_bit) begin
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          emit   = 1'b1;
          if (idx_q != '0) begin
            idx_d = idx_q - LEN_W'(1);
            sel   = pat_q >> (idx_q - LEN_W'(1));
          end else begin
            // Back-to-back reload: no gap between repetitions
            idx_d = len_q - LEN_W'(1);
            rep_d = rep_q - CNT_W'(1);
            sel   = pat_q >> (len_q - LEN_W'(1));
          end
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
    emit_bit = sel[0];
    if (emit) begin
      x_d     = emit_bit;
      valid_d = 1'b1;
      // Only count once two real bits precede this one since start
      if ((hist_n_d == 2'd2) && (hist_d == 2'b01) && !emit_bit && (cnt_d != '1)) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
      hist_d = {hist_d[0], emit_bit};
      if (hist_n_d != 2'd2) hist_n_d = hist_n_d + 2'd1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rep_q    <= '0;
      hist_q   <= '0;
      hist_n_q <= '0;
      cnt_q    <= '0;
      x_q      <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      hist_q   <= hist_d;
      hist_n_q <= hist_n_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x         = x_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: vector table plus hand-written abort and
// saturation sequences; expected bits are queued at start and popped per valid.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [7:0]  repeat_n = '0;
  logic        x, valid, busy, done;
  logic [7:0]  match_cnt;

  logic        start2 = 1'b0;
  logic [15:0] pattern2 = '0;
  logic [4:0]  len2 = '0;
  logic [3:0]  repeat_n2 = '0;
  logic        x2, valid2, busy2, done2;
  logic [3:0]  match_cnt2;

  int n_chk = 0;
  int n_pass = 0;
  logic expq[$];

  always #5 clk = ~clk;

  sequence_generator dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .repeat_n(repeat_n), .x(x), .valid(valid), .busy(busy), .done(done),
    .match_cnt(match_cnt)
  );

  sequence_generator #(.MAX_LEN(16), .LEN_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .pattern(pattern2), .len(len2),
    .repeat_n(repeat_n2), .x(x2), .valid(valid2), .busy(busy2), .done(done2),
    .match_cnt(match_cnt2)
  );

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [7:0]  rep;
    logic [7:0]  exp_cnt;
    int          extra_start; // cycle in which start is pulsed again (0 = none)
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_model(input logic [15:0] p, input int eff, input int r);
    logic [15:0] t;
    for (int rr = 0; rr < r; rr++) begin
      for (int b = eff - 1; b >= 0; b--) begin
        t = p >> b;
        expq.push_back(t[0]);
      end
    end
  endtask

  // Called at a falling edge; cycle 1 is the cycle after the start edge
  task automatic run_xfer(input vec_t v, input string name);
    int eff, total, nvalid, done_cyc, spur;
    logic [7:0] cnt_done;
    logic exp_bit;
    eff = (v.len > 5'd16) ? 16 : int'(v.len);
    total = eff * int'(v.rep);
    nvalid = 0;
    done_cyc = -1;
    cnt_done = '0;
    push_model(v.pat, eff, int'(v.rep));
    pattern = v.pat; len = v.len; repeat_n = v.rep; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= total + 5; k++) begin
      if (k == 1) check({name, " busy@1"}, 32'(busy), 32'd1);
      if (valid) begin
        nvalid++;
        if (expq.size() == 0) check({name, " extra bit"}, 32'(x), 32'hx);
        else begin
          exp_bit = expq.pop_front();
          check($sformatf("%s bit%0d", name, k), 32'(x), 32'(exp_bit));
        end
      end else begin
        check($sformatf("%s x idle%0d", name, k), 32'(x), 32'd0);
      end
      start = (k == v.extra_start);
      if (done) begin
        done_cyc = k;
        cnt_done = match_cnt;
        check({name, " busy@done"}, 32'(busy), (total == 0) ? 32'd1 : 32'd0);
        break;
      end
      @(negedge clk);
    end
    spur = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || valid || busy) spur++;
    end
    check({name, " done cycle"}, 32'(done_cyc), 32'(total + 1));
    check({name, " valid count"}, 32'(nvalid), 32'(total));
    check({name, " bits left"}, 32'(expq.size()), 32'd0);
    check({name, " match_cnt"}, 32'(cnt_done), 32'(v.exp_cnt));
    check({name, " cnt hold"}, 32'(match_cnt), 32'(v.exp_cnt));
    check({name, " quiet after"}, 32'(spur), 32'd0);
    expq.delete();
  endtask

  initial begin
    vecs[0]  = '{16'h0002, 5'd3,  8'd1, 8'd1,  0};
    vecs[1]  = '{16'h0012, 5'd5,  8'd2, 8'd3,  0};
    vecs[2]  = '{16'h0012, 5'd5,  8'd2, 8'd3,  4};
    vecs[3]  = '{16'h0002, 5'd3,  8'd1, 8'd1,  4};
    vecs[4]  = '{16'h0000, 5'd0,  8'd3, 8'd0,  0};
    vecs[5]  = '{16'h00FF, 5'd4,  8'd0, 8'd0,  1};
    vecs[6]  = '{16'hAAAA, 5'd16, 8'd2, 8'd15, 0};
    vecs[7]  = '{16'h4002, 5'd20, 8'd1, 8'd2,  0};
    vecs[8]  = '{16'h0005, 5'd4,  8'd3, 8'd5,  0};
    vecs[9]  = '{16'h0001, 5'd2,  8'd1, 8'd0,  0};
    vecs[10] = '{16'h0000, 5'd1,  8'd1, 8'd0,  0};

    repeat (3) @(negedge clk);
    check("reset outs", {28'd0, x, valid, busy, done}, 32'd0);
    check("reset cnt", 32'(match_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle outs", {28'd0, x, valid, busy, done}, 32'd0);

    for (int i = 0; i < 11; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous abort in cycle 5 of a 10-bit transfer
    pattern = 16'h0012; len = 5'd5; repeat_n = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort pre cnt", 32'(match_cnt), 32'd1);
    check("abort pre valid", 32'(valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort outs", {22'd0, x, valid, busy, match_cnt}, 32'd0);
    begin
      int seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("abort no done", 32'(seen_done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    run_xfer(vecs[1], "after abort");

    // Saturating counter: 60 alternating bits, raw count 29
    begin
      int nvalid = 0;
      int done_cyc = -1;
      logic exp_bit;
      push_model(16'h0005, 4, 15);
      pattern2 = 16'h0005; len2 = 5'd4; repeat_n2 = 4'd15; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 1; k <= 70; k++) begin
        if (valid2) begin
          nvalid++;
          exp_bit = (expq.size() != 0) ? expq.pop_front() : 1'bx;
          check($sformatf("sat bit%0d", k), 32'(x2), 32'(exp_bit));
        end
        if (done2) begin
          done_cyc = k;
          break;
        end
        @(negedge clk);
      end
      check("sat done cycle", 32'(done_cyc), 32'd61);
      check("sat valid count", 32'(nvalid), 32'd60);
      check("sat match_cnt", 32'(match_cnt2), 32'hF);
      expq.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
